// File: rtl/dbf_ch_param.sv
// Single-channel delay-and-sum slice: delay LUT, coarse-delay ring buffer,
// linear fine-delay interpolation and apodisation in a four-stage pipeline.
module dbf_ch_param #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int ADDR_WD  = 10,
  parameter int CD_AW    = 8,
  parameter int FRAC_WD  = 4,
  parameter int OUT_WD   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_en,
  input  logic                     start,
  input  logic [INPUT_WD-1:0]      ch_in,
  input  logic [APO_WD-1:0]        apo_din,
  input  logic                     lut_wr_en,
  input  logic [ADDR_WD-1:0]       lut_wr_addr,
  input  logic [CD_AW+FRAC_WD-1:0] lut_wr_data,
  output logic [OUT_WD-1:0]        dout,
  output logic                     dout_valid,
  output logic [INPUT_WD-1:0]      cd_dout,
  output logic                     delay_err
);
  localparam int LW  = CD_AW + FRAC_WD;
  localparam int IPW = INPUT_WD + FRAC_WD + 2;
  localparam int PW  = IPW + APO_WD;
  localparam logic [CD_AW-1:0]   MAX_C    = {{(CD_AW-1){1'b1}}, 1'b0};
  localparam logic [CD_AW-1:0]   ONE_C    = CD_AW'(1'b1);
  localparam logic [CD_AW:0]     ONE_F    = (CD_AW+1)'(1'b1);
  localparam logic [CD_AW:0]     FILL_MAX = {1'b1, {CD_AW{1'b0}}};
  localparam logic [ADDR_WD-1:0] ONE_A    = ADDR_WD'(1'b1);
  localparam logic [ADDR_WD-1:0] ADDR_MAX = {ADDR_WD{1'b1}};
  localparam logic [FRAC_WD:0]   FULL_W   = {1'b1, {FRAC_WD{1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  state_e state_q, state_d;
  logic   run_s, accept_s;

  logic [LW-1:0]       lut_mem [0:(1<<ADDR_WD)-1];
  logic [INPUT_WD-1:0] buf_mem [0:(1<<CD_AW)-1];

  logic [CD_AW-1:0]    wr_ptr_q;
  logic [CD_AW:0]      fill_q;
  logic [ADDR_WD-1:0]  lut_addr_q;
  logic [LW-1:0]       lut_rd_q;
  logic                v1_q, v2_q, v3_q, dout_valid_q, delay_err_q;
  logic [INPUT_WD-1:0] s0_q, s1_q, s0_3_q, cd_q;
  logic [FRAC_WD-1:0]  frac2_q;
  logic signed [IPW-1:0] interp_q;
  logic [APO_WD-1:0]   apo_q;
  logic [OUT_WD-1:0]   dout_q;

  logic [CD_AW-1:0]    c_raw_s, c_s, newest_s, idx0_s, idx1_s;
  logic [CD_AW:0]      c_ext_s;
  logic                illegal_s, tap0_ok_s, tap1_ok_s;
  logic [FRAC_WD:0]    w0_s, w1_s;
  logic signed [IPW-1:0] interp_s;
  logic signed [PW-1:0]  prod_s, shift_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: the line runs exactly while start is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A falling start flushes in the same cycle, so run_s also needs start.
  always_comb begin
    run_s    = (state_q == RUN) && start;
    accept_s = run_s && !tx_en;
  end

  // Delay LUT and ring buffer; simultaneous read of a written address sees old data.
  always_ff @(posedge clk) begin
    if (lut_wr_en) lut_mem[lut_wr_addr] <= lut_wr_data;
    if (accept_s)  buf_mem[wr_ptr_q]    <= ch_in;
  end

  // Stage 2 tap addressing: wr_ptr_q-1 is the sample accepted in stage 1.
  always_comb begin
    c_raw_s   = lut_rd_q[LW-1:FRAC_WD];
    illegal_s = (c_raw_s > MAX_C);
    c_s       = illegal_s ? MAX_C : c_raw_s;
    c_ext_s   = {1'b0, c_s};
    newest_s  = wr_ptr_q - ONE_C;
    idx0_s    = newest_s - c_s;
    idx1_s    = idx0_s - ONE_C;
    tap0_ok_s = (c_ext_s < fill_q);
    tap1_ok_s = ((c_ext_s + ONE_F) < fill_q);
  end

  // Stage 3 interpolation and stage 4 apodisation arithmetic.
  always_comb begin
    w0_s     = FULL_W - {1'b0, frac2_q};
    w1_s     = {1'b0, frac2_q};
    interp_s = IPW'($signed(s0_q)) * IPW'($signed({1'b0, w0_s}))
             + IPW'($signed(s1_q)) * IPW'($signed({1'b0, w1_s}));
    prod_s   = PW'(interp_q) * PW'($signed(apo_q));
    shift_s  = prod_s >>> FRAC_WD;
  end

  // Pointers and pipeline registers; leaving RUN clears everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0; fill_q <= '0; lut_addr_q <= '0; lut_rd_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; dout_valid_q <= 1'b0;
      s0_q <= '0; s1_q <= '0; s0_3_q <= '0; frac2_q <= '0;
      interp_q <= '0; apo_q <= '0; dout_q <= '0; cd_q <= '0;
    end else if (!run_s) begin
      wr_ptr_q <= '0; fill_q <= '0; lut_addr_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; dout_valid_q <= 1'b0;
      dout_q <= '0; cd_q <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_q   <= wr_ptr_q + ONE_C;
        fill_q     <= (fill_q == FILL_MAX) ? FILL_MAX : fill_q + ONE_F;
        lut_addr_q <= (lut_addr_q == ADDR_MAX) ? ADDR_MAX : lut_addr_q + ONE_A;
      end
      lut_rd_q     <= lut_mem[lut_addr_q];
      v1_q         <= accept_s;
      v2_q         <= v1_q;
      s0_q         <= (v1_q && tap0_ok_s) ? buf_mem[idx0_s] : '0;
      s1_q         <= (v1_q && tap1_ok_s) ? buf_mem[idx1_s] : '0;
      frac2_q      <= lut_rd_q[FRAC_WD-1:0];
      v3_q         <= v2_q;
      interp_q     <= interp_s;
      apo_q        <= apo_din;
      s0_3_q       <= s0_q;
      dout_valid_q <= v3_q;
      dout_q       <= v3_q ? OUT_WD'(shift_s) : '0;
      cd_q         <= v3_q ? s0_3_q : '0;
    end
  end

  // Sticky illegal-delay flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          delay_err_q <= 1'b0;
    else if (run_s && v1_q && illegal_s) delay_err_q <= 1'b1;
    else                                 delay_err_q <= delay_err_q;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign cd_dout    = cd_q;
  assign delay_err  = delay_err_q;
endmodule

// File: tb/tb_dbf_ch_param.sv
// Self-checking bench for dbf_ch_param: directed table, hand sequences and
// randomized traffic against a history-queue reference model.
module tb_dbf_ch_param;
  localparam int IW = 14, AW = 16, ADW = 10, CAW = 8, FW = 4, OW = 32, NMAX = 2048;

  logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, start = 1'b0, lut_wr_en = 1'b0;
  logic [IW-1:0]      ch_in = '0;
  logic [AW-1:0]      apo_din = '0;
  logic [ADW-1:0]     lut_wr_addr = '0;
  logic [CAW+FW-1:0]  lut_wr_data = '0;
  logic [OW-1:0]      dout;
  logic               dout_valid;
  logic [IW-1:0]      cd_dout;
  logic               delay_err;

  int checks = 0, errors = 0;

  bit     st_a[NMAX], tx_a[NMAX], we_a[NMAX], ev[NMAX], eerr[NMAX], obs_v[NMAX];
  int     ch_a[NMAX], ap_a[NMAX], wa_a[NMAX], wd_a[NMAX], ecd[NMAX];
  longint ed[NMAX], obs_d[NMAX];
  bit     runm[NMAX];
  int     lut_m[1024];
  bit     model_err = 1'b0;

  typedef struct {
    bit st; bit tx; int ch; int ap;
    bit ev; int ed; int ecd;
  } vec_t;
  vec_t tbl[12];

  dbf_ch_param dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start), .ch_in(ch_in),
    .apo_din(apo_din), .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .dout(dout), .dout_valid(dout_valid),
    .cd_dout(cd_dout), .delay_err(delay_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // One clock: inputs applied, then outputs sampled 1 time unit after the edge.
  task automatic drive(input bit st, input bit tx, input int ch, input int ap,
                       input bit we, input int wa, input int wd);
    start = st; tx_en = tx; ch_in = IW'(ch); apo_din = AW'(ap);
    lut_wr_en = we; lut_wr_addr = ADW'(wa); lut_wr_data = 12'(wd);
    @(posedge clk); #1;
  endtask

  task automatic lut_fill(input int lo, input int hi, input int d);
    for (int a = lo; a <= hi; a++) begin
      drive(1'b0, 1'b0, 0, 0, 1'b1, a, d);
      lut_m[a] = d;
    end
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Reference: keep every accepted sample of the line, pick taps by age.
  task automatic build_model(input int n);
    int q[$];
    int la, e, c, f, s0, s1, nn;
    longint ip, pr;
    la = 0;
    for (int t = 0; t < n; t++) begin
      ev[t] = 1'b0; ed[t] = 0; ecd[t] = 0; eerr[t] = model_err;
      runm[t] = (t > 0) ? (st_a[t-1] && st_a[t]) : 1'b0;
    end
    for (int t = 0; t < n; t++) begin
      if (!runm[t]) begin
        q.delete(); la = 0;
      end else if (!tx_a[t]) begin
        e = lut_m[la]; c = (e >> 4) & 255; f = e & 15;
        if (c > 254) begin
          c = 254;
          if (t + 1 < n && runm[t+1])
            for (int k = t + 1; k < n; k++) eerr[k] = 1'b1;
        end
        q.push_back(ch_a[t]);
        nn = q.size();
        s0 = (c < nn) ? q[nn-1-c] : 0;
        s1 = (c + 1 < nn) ? q[nn-2-c] : 0;
        if (t + 3 < n && runm[t+1] && runm[t+2] && runm[t+3]) begin
          ip = longint'(s0) * (16 - f) + longint'(s1) * f;
          pr = ip * longint'(ap_a[t+2]);
          ev[t+3] = 1'b1; ed[t+3] = pr >>> 4; ecd[t+3] = s0;
        end
        if (la < 1023) la++;
      end
      if (we_a[t]) lut_m[wa_a[t]] = wd_a[t];
    end
  endtask

  task automatic apply(input int n, input string tag);
    build_model(n);
    for (int t = 0; t < n; t++) begin
      drive(st_a[t], tx_a[t], ch_a[t], ap_a[t], we_a[t], wa_a[t], wd_a[t]);
      obs_v[t] = dout_valid; obs_d[t] = longint'($signed(dout));
      chk({tag, " valid"}, longint'(dout_valid), longint'(ev[t]));
      chk({tag, " dout"},  longint'($signed(dout)), ed[t]);
      chk({tag, " cd"},    longint'($signed(cd_dout)), longint'(ecd[t]));
      chk({tag, " err"},   longint'(delay_err), longint'(eerr[t]));
    end
    model_err = eerr[n-1];
  endtask

  task automatic clear_stim(input int n);
    for (int t = 0; t < n; t++) begin
      st_a[t] = 1'b0; tx_a[t] = 1'b0; we_a[t] = 1'b0;
      ch_a[t] = 0; ap_a[t] = 1; wa_a[t] = 0; wd_a[t] = 0;
    end
  endtask

  function automatic int rand_entry();
    int c, f;
    c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 20));
    f = int'($urandom_range(0, 15));
    return c * 16 + f;
  endfunction

  initial begin
    int n, gaps, nval, j;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", longint'(dout_valid), 0);
    chk("rst dout",  longint'(dout), 0);
    chk("rst cd",    longint'(cd_dout), 0);
    chk("rst err",   longint'(delay_err), 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

    // Zero delay, unit weight: ramp passes through after 4 cycles
    lut_fill(0, 31, 0);
    drive(1'b1, 1'b0, 0, 1, 1'b0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, k + 1, 1, 1'b0, 0, 0);
      if (k >= 3) begin
        chk("ramp valid", longint'(dout_valid), 1);
        chk("ramp dout",  longint'($signed(dout)), k - 2);
      end else begin
        chk("ramp fill valid", longint'(dout_valid), 0);
      end
    end
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);

    // Coarse delay 3, weight 2
    lut_fill(0, 31, 12'h030);
    drive(1'b1, 1'b0, 0, 2, 1'b0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, k + 1, 2, 1'b0, 0, 0);
      if (k >= 3) begin
        j = k - 3;
        chk("c3 valid", longint'(dout_valid), 1);
        chk("c3 dout",  longint'($signed(dout)), (j < 3) ? 0 : 2 * (j - 2));
        chk("c3 cd",    longint'($signed(cd_dout)), (j < 3) ? 0 : j - 2);
      end
    end
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);

    // Half-sample fraction with a step input, then line end
    lut_fill(0, 15, 12'h008);
    tbl[0]  = '{1'b1, 1'b0, 100, 1, 1'b0, 0,   0};
    tbl[1]  = '{1'b1, 1'b0, 100, 1, 1'b0, 0,   0};
    tbl[2]  = '{1'b1, 1'b0, 100, 1, 1'b0, 0,   0};
    tbl[3]  = '{1'b1, 1'b0, 100, 1, 1'b0, 0,   0};
    tbl[4]  = '{1'b1, 1'b0, 200, 1, 1'b1, 50,  100};
    tbl[5]  = '{1'b1, 1'b0, 200, 1, 1'b1, 100, 100};
    tbl[6]  = '{1'b1, 1'b0, 200, 1, 1'b1, 100, 100};
    tbl[7]  = '{1'b1, 1'b0, 200, 1, 1'b1, 150, 200};
    tbl[8]  = '{1'b1, 1'b0, 200, 1, 1'b1, 200, 200};
    tbl[9]  = '{1'b0, 1'b0, 200, 1, 1'b0, 0,   0};
    tbl[10] = '{1'b0, 1'b0, 200, 1, 1'b0, 0,   0};
    tbl[11] = '{1'b0, 1'b0, 200, 1, 1'b0, 0,   0};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, tbl[i].tx, tbl[i].ch, tbl[i].ap, 1'b0, 0, 0);
      chk($sformatf("frac row%0d valid", i), longint'(dout_valid), longint'(tbl[i].ev));
      chk($sformatf("frac row%0d dout", i),  longint'($signed(dout)), longint'(tbl[i].ed));
      chk($sformatf("frac row%0d cd", i),    longint'($signed(cd_dout)), longint'(tbl[i].ecd));
    end

    // Two transmit bubbles mid-stream
    lut_fill(0, 31, 0);
    n = 20; clear_stim(n);
    for (int t = 0; t < n; t++) begin
      st_a[t] = (t <= 16); ch_a[t] = t + 1; tx_a[t] = (t == 6 || t == 7);
    end
    apply(n, "bubble");
    gaps = 0; nval = 0;
    for (int t = 4; t <= 16; t++) begin
      if (!obs_v[t]) gaps++;
      else nval++;
    end
    chk("bubble gaps", gaps, 2);
    chk("bubble count", nval, 11);

    // Line restart: address 0 holds c=1, so a restarted empty line yields 0 first
    lut_fill(0, 31, 0);
    lut_fill(0, 0, 12'h010);
    n = 20; clear_stim(n);
    for (int t = 0; t < n; t++) begin
      st_a[t] = (t != 8 && t != 19); ch_a[t] = (t < 9) ? t + 1 : 1000 + t;
    end
    apply(n, "restart");
    chk("restart drop valid", longint'(obs_v[8]), 0);
    chk("restart first valid", longint'(obs_v[13]), 1);
    chk("restart first dout", obs_d[13], 0);
    chk("restart second dout", obs_d[14], 1011);

    // Reset in the middle of a line
    lut_fill(0, 31, 0);
    drive(1'b1, 1'b0, 0, 1, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, 50 + k, 1, 1'b0, 0, 0);
    rst_n = 1'b0; #2;
    chk("midrst valid", longint'(dout_valid), 0);
    chk("midrst dout",  longint'(dout), 0);
    chk("midrst cd",    longint'(cd_dout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 70 + k, 1, 1'b0, 0, 0);
      chk("postrst valid", longint'(dout_valid), 0);
    end
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);

    // Illegal coarse delay 255 clamps to 254
    lut_fill(0, 299, 12'hFF0);
    n = 275; clear_stim(n);
    for (int t = 0; t < n; t++) begin
      st_a[t] = (t < 272); ch_a[t] = t;
    end
    apply(n, "clamp");
    chk("clamp tap", obs_d[261], 4);
    chk("clamp err", longint'(delay_err), 1);
    for (int k = 0; k < 4; k++) begin
      drive(k % 2 == 0, 1'b0, 0, 1, 1'b0, 0, 0);
      chk("err sticky", longint'(delay_err), 1);
    end
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);
    rst_n = 1'b0; #2;
    chk("err reset", longint'(delay_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_err = 1'b0;
    drive(1'b0, 1'b0, 0, 1, 1'b0, 0, 0);

    // Randomized traffic with live LUT rewrites
    for (int a = 0; a < 1024; a++) lut_fill(a, a, rand_entry());
    n = 900; clear_stim(n);
    for (int t = 0; t < n; t++) begin
      st_a[t] = (t < n - 1) && ($urandom_range(0, 39) != 0);
      tx_a[t] = ($urandom_range(0, 6) == 0);
      ch_a[t] = int'($urandom_range(0, 16383)) - 8192;
      ap_a[t] = int'($urandom_range(0, 65535)) - 32768;
      we_a[t] = ($urandom_range(0, 19) == 0);
      wa_a[t] = int'($urandom_range(0, 63));
      wd_a[t] = rand_entry();
    end
    apply(n, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
